// File: rtl/ldpc_3gpp_enc_waddr_gen_pkg.sv
// Shared types for the LDPC 3GPP encoder input-buffer write side.
package ldpc_3gpp_enc_waddr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } wstate_t;

    // Lane count word used by both buffer sides; sized for the widest supported word.
    localparam int cMAX_LOG2_DAT_W = 8;
    typedef logic [cMAX_LOG2_DAT_W:0] lane_cnt_t;

endpackage

// File: rtl/ldpc_3gpp_enc_waddr_gen_wpack.sv
// Lane accumulator: packs iused_dat_w-lane groups LSB first into one pDAT_W-lane word.
module ldpc_3gpp_enc_wpack
    import ldpc_3gpp_enc_waddr_gen_pkg::*;
#(
    parameter int pDAT_W      = 8,
    parameter int cLOG2_DAT_W = $clog2(pDAT_W)
) (
    input  logic                   iclk,
    input  logic                   ireset,
    input  logic                   iclkena,
    input  logic                   iclear,
    input  logic                   ival,
    input  logic [cLOG2_DAT_W:0]   iused_dat_w,
    input  logic [pDAT_W-1:0]      idat,
    output logic [pDAT_W-1:0]      oword,
    output logic                   ocomplete
);

    localparam logic [cLOG2_DAT_W+1:0] cDAT_W_L = (cLOG2_DAT_W+2)'(pDAT_W);

    logic [cLOG2_DAT_W:0]   pos_q, pos_d;
    logic [pDAT_W-1:0]      acc_q, acc_d;
    logic [cLOG2_DAT_W+1:0] sum_s;
    logic [pDAT_W-1:0]      mask_s;
    logic [pDAT_W-1:0]      word_s;
    logic                   complete_s;

    // Merge the current group into the accumulator and compute the next pointer.
    always_comb begin
        sum_s      = {1'b0, pos_q} + {1'b0, iused_dat_w};
        mask_s     = ({pDAT_W{1'b1}} >> (cDAT_W_L - {1'b0, iused_dat_w})) << pos_q;
        word_s     = (acc_q & ~mask_s) | ((idat << pos_q) & mask_s);
        complete_s = ival && (sum_s == cDAT_W_L);
        pos_d      = pos_q;
        acc_d      = acc_q;
        if (iclear) begin
            pos_d = '0;
            acc_d = '0;
        end else if (complete_s) begin
            pos_d = '0;
            acc_d = '0;
        end else if (ival) begin
            pos_d = sum_s[cLOG2_DAT_W:0];
            acc_d = word_s;
        end else begin
            pos_d = pos_q;
        end
    end

    // Pointer and accumulator registers.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            pos_q <= '0;
            acc_q <= '0;
        end else if (iclkena) begin
            pos_q <= pos_d;
            acc_q <= acc_d;
        end
    end

    assign oword     = word_s;
    assign ocomplete = complete_s;

endmodule

// File: rtl/ldpc_3gpp_enc_waddr_gen.sv
// Encoder input-buffer write address/data generator.
// Optional macro LDPC_3GPP_ENC_WADDR_OVF_CHECK_EN enables the sticky oerr overflow flag.
module ldpc_3gpp_enc_waddr_gen
    import ldpc_3gpp_enc_waddr_gen_pkg::*;
#(
    parameter int pADDR_W        = 8,
    parameter int pDAT_W         = 8,
    parameter int pUSE_VAR_DAT_W = 0,
    parameter int cLOG2_DAT_W    = $clog2(pDAT_W)
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic [cLOG2_DAT_W:0] iused_dat_w,
    input  logic [pADDR_W:0]     inum_words,
    input  logic                 iclear,
    input  logic                 ival,
    input  logic [pDAT_W-1:0]    idat,
    output logic [pADDR_W-1:0]   owaddr,
    output logic [pDAT_W-1:0]    owdat,
    output logic                 owrite,
    output logic                 owdone,
    output logic                 obusy,
    output logic                 oerr
);

    wstate_t              state_q, state_d;
    logic [pADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [pADDR_W:0]     num_words_q, num_words_d;
    logic [pADDR_W-1:0]   owaddr_q, owaddr_d;
    logic [pDAT_W-1:0]    owdat_q, owdat_d;
    logic                 owrite_q, owrite_d;
    logic                 owdone_q, owdone_d;
    logic                 obusy_q, obusy_d;
    logic                 val_fill_s;
    logic                 last_s;
    logic [pDAT_W-1:0]    word_s;
    logic                 complete_s;

    assign val_fill_s = ival && !iclear && (state_q == FILL);
    assign last_s     = ({1'b0, word_cnt_q} == (num_words_q - (pADDR_W+1)'(1)));

    generate
        if (pUSE_VAR_DAT_W != 0) begin : g_var
            ldpc_3gpp_enc_wpack #(
                .pDAT_W      (pDAT_W),
                .cLOG2_DAT_W (cLOG2_DAT_W)
            ) u_wpack (
                .iclk        (iclk),
                .ireset      (ireset),
                .iclkena     (iclkena),
                .iclear      (iclear),
                .ival        (val_fill_s),
                .iused_dat_w (iused_dat_w),
                .idat        (idat),
                .oword       (word_s),
                .ocomplete   (complete_s)
            );
        end else begin : g_fix
            logic unused_used_s;
            assign unused_used_s = ^iused_dat_w;
            assign word_s        = idat;
            assign complete_s    = val_fill_s;
        end
    endgenerate

    // Next-state, word counter and write-port computation.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        num_words_d = num_words_q;
        owaddr_d    = owaddr_q;
        owdat_d     = owdat_q;
        owrite_d    = 1'b0;
        owdone_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iclear) state_d = FILL;
                else        state_d = IDLE;
            end
            FILL: begin
                if (iclear)                    state_d = FILL;
                else if (complete_s && last_s) state_d = DONE;
                else                           state_d = FILL;
            end
            DONE: begin
                if (iclear) state_d = FILL;
                else        state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (iclear) begin
            word_cnt_d  = '0;
            num_words_d = inum_words;
            owaddr_d    = '0;
        end else if (complete_s) begin
            owrite_d   = 1'b1;
            owdone_d   = last_s;
            owdat_d    = word_s;
            owaddr_d   = word_cnt_q;
            word_cnt_d = word_cnt_q + pADDR_W'(1);
        end else begin
            owrite_d = 1'b0;
        end
        obusy_d = (state_d == FILL);
    end

    // State and output registers.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            num_words_q <= '0;
            owaddr_q    <= '0;
            owdat_q     <= '0;
            owrite_q    <= 1'b0;
            owdone_q    <= 1'b0;
            obusy_q     <= 1'b0;
        end else if (iclkena) begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            num_words_q <= num_words_d;
            owaddr_q    <= owaddr_d;
            owdat_q     <= owdat_d;
            owrite_q    <= owrite_d;
            owdone_q    <= owdone_d;
            obusy_q     <= obusy_d;
        end
    end

`ifdef LDPC_3GPP_ENC_WADDR_OVF_CHECK_EN
    logic oerr_q, oerr_d;

    // Sticky flag for data arriving outside a block.
    always_comb begin
        oerr_d = oerr_q;
        if (iclear)                          oerr_d = 1'b0;
        else if (ival && (state_q != FILL))  oerr_d = 1'b1;
        else                                 oerr_d = oerr_q;
    end

    // Overflow flag register.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset)      oerr_q <= 1'b0;
        else if (iclkena) oerr_q <= oerr_d;
    end

    assign oerr = oerr_q;
`else
    assign oerr = 1'b0;
`endif

    assign owaddr = owaddr_q;
    assign owdat  = owdat_q;
    assign owrite = owrite_q;
    assign owdone = owdone_q;
    assign obusy  = obusy_q;

endmodule

// File: tb/tb_ldpc_3gpp_enc_waddr_gen.sv
// Directed bench: one fixed-width and one variable-width instance share the stimulus.
module tb_ldpc_3gpp_enc_waddr_gen;

    logic       iclk = 1'b0;
    logic       ireset;
    logic       iclkena;
    logic [3:0] iused_dat_w;
    logic [8:0] inum_words;
    logic       iclear;
    logic       ival;
    logic [7:0] idat;

    logic [7:0] f_waddr, v_waddr;
    logic [7:0] f_wdat,  v_wdat;
    logic       f_write, v_write, f_done, v_done, f_busy, v_busy, f_err, v_err;

    int checks   = 0;
    int failures = 0;

`ifdef LDPC_3GPP_ENC_WADDR_OVF_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    always #5 iclk = ~iclk;

    ldpc_3gpp_enc_waddr_gen #(.pADDR_W(8), .pDAT_W(8), .pUSE_VAR_DAT_W(0)) u_fix (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iused_dat_w(iused_dat_w),
        .inum_words(inum_words), .iclear(iclear), .ival(ival), .idat(idat),
        .owaddr(f_waddr), .owdat(f_wdat), .owrite(f_write), .owdone(f_done),
        .obusy(f_busy), .oerr(f_err)
    );

    ldpc_3gpp_enc_waddr_gen #(.pADDR_W(8), .pDAT_W(8), .pUSE_VAR_DAT_W(1)) u_var (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iused_dat_w(iused_dat_w),
        .inum_words(inum_words), .iclear(iclear), .ival(ival), .idat(idat),
        .owaddr(v_waddr), .owdat(v_wdat), .owrite(v_write), .owdone(v_done),
        .obusy(v_busy), .oerr(v_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic blk_start(input logic [8:0] n, input logic [3:0] used);
        iclear      = 1'b1;
        ival        = 1'b0;
        inum_words  = n;
        iused_dat_w = used;
        step();
        iclear = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        ival = 1'b1;
        idat = d;
        step();
        ival = 1'b0;
    endtask

    initial begin
        ireset = 1'b0; iclkena = 1'b1; iclear = 1'b0; ival = 1'b0;
        idat = 8'h00; iused_dat_w = 4'd8; inum_words = 9'd3;
        #12;
        chk("rst_f_write", f_write, 1'b0);
        chk("rst_f_busy",  f_busy,  1'b0);
        chk("rst_v_addr",  v_waddr, 8'h00);
        chk("rst_v_dat",   v_wdat,  8'h00);
        chk("rst_v_err",   v_err,   1'b0);
        @(negedge iclk);
        ireset = 1'b1;

        // 1: fixed words, var with used=8 behaves the same
        blk_start(9'd3, 4'd8);
        chk("t1_busy", f_busy, 1'b1);
        chk("t1_idle_wr", f_write, 1'b0);
        send(8'hA1);
        chk("t1_w0_f", {f_write, f_done, f_waddr, f_wdat}, {1'b1, 1'b0, 8'd0, 8'hA1});
        chk("t1_w0_v", {v_write, v_done, v_waddr, v_wdat}, {1'b1, 1'b0, 8'd0, 8'hA1});
        send(8'hA2);
        chk("t1_w1_f", {f_write, f_done, f_waddr, f_wdat}, {1'b1, 1'b0, 8'd1, 8'hA2});
        send(8'hA3);
        chk("t1_w2_f", {f_write, f_done, f_waddr, f_wdat, f_busy}, {1'b1, 1'b1, 8'd2, 8'hA3, 1'b0});
        chk("t1_w2_v", {v_write, v_done, v_waddr, v_wdat, v_busy}, {1'b1, 1'b1, 8'd2, 8'hA3, 1'b0});
        step();
        chk("t1_after", {f_write, f_done, f_busy}, 3'b000);

        // 2: var used=2, groups 01,10,11,00 -> 8'h39
        blk_start(9'd1, 4'd2);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("t2_partial", v_write, 1'b0);
        send(8'h00);
        chk("t2_word", {v_write, v_done, v_waddr, v_wdat}, {1'b1, 1'b1, 8'd0, 8'h39});

        // 3: var used=1, bits 1,0,0,0,0,0,0,1 -> 8'h81
        blk_start(9'd1, 4'd1);
        for (int i = 0; i < 8; i++) begin
            send((i == 0 || i == 7) ? 8'h01 : 8'h00);
            if (i == 6) chk("t3_partial", v_write, 1'b0);
        end
        chk("t3_word", {v_write, v_done, v_waddr, v_wdat}, {1'b1, 1'b1, 8'd0, 8'h81});

        // 4: iclear with ival mid-block restarts at address 0
        blk_start(9'd3, 4'd8);
        send(8'hA1);
        chk("t4_w0", {f_write, f_waddr}, {1'b1, 8'd0});
        iclear = 1'b1; ival = 1'b1; idat = 8'hFF;
        step();
        iclear = 1'b0; ival = 1'b0;
        chk("t4_drop_f", {f_write, f_busy}, 2'b01);
        chk("t4_drop_v", {v_write, v_busy}, 2'b01);
        send(8'hB0);
        chk("t4_restart_f", {f_write, f_waddr, f_wdat}, {1'b1, 8'd0, 8'hB0});
        chk("t4_restart_v", {v_write, v_waddr, v_wdat}, {1'b1, 8'd0, 8'hB0});

        // 5: async reset mid-word (pos=4)
        blk_start(9'd2, 4'd2);
        send(8'h01);
        send(8'h01);
        chk("t5_pre", {v_busy, v_wdat}, {1'b1, 8'hB0});
        #2;
        ireset = 1'b0;
        #1;
        chk("t5_rst_v", {v_write, v_done, v_busy, v_waddr, v_wdat}, {1'b0, 1'b0, 1'b0, 8'd0, 8'h00});
        chk("t5_rst_f", {f_busy, f_wdat}, {1'b0, 8'h00});
        @(negedge iclk);
        ireset = 1'b1;
        blk_start(9'd2, 4'd2);
        send(8'h02);
        send(8'h00);
        send(8'h00);
        send(8'h03);
        chk("t5_fresh", {v_write, v_done, v_waddr, v_wdat}, {1'b1, 1'b0, 8'd0, 8'hC2});

        // 6: ival after the block has completed
        blk_start(9'd1, 4'd8);
        send(8'h55);
        chk("t6_done", {f_write, f_done, f_err}, {1'b1, 1'b1, 1'b0});
        send(8'h66);
        chk("t6_nowr", {f_write, v_write}, 2'b00);
        chk("t6_err_f", f_err, OVF_EXP);
        step();
        chk("t6_err_v", v_err, OVF_EXP);
        blk_start(9'd1, 4'd8);
        chk("t6_clr", {f_err, v_err}, 2'b00);

        // 7: clock enable low freezes everything
        blk_start(9'd3, 4'd8);
        send(8'h11);
        chk("t7_w0", {f_write, f_waddr, f_wdat}, {1'b1, 8'd0, 8'h11});
        iclkena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ival = ~ival;
            idat = 8'hEE;
            step();
            chk("t7_hold_f", {f_write, f_waddr, f_wdat, f_busy}, {1'b1, 8'd0, 8'h11, 1'b1});
            chk("t7_hold_v", {v_write, v_waddr, v_wdat}, {1'b1, 8'd0, 8'h11});
        end
        ival = 1'b0;
        iclkena = 1'b1;
        send(8'h22);
        chk("t7_w1", {f_write, f_done, f_waddr, f_wdat}, {1'b1, 1'b0, 8'd1, 8'h22});
        send(8'h33);
        chk("t7_w2", {v_write, v_done, v_waddr, v_wdat}, {1'b1, 1'b1, 8'd2, 8'h33});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
